// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch stage for the 16-bit single-cycle datapath. Holds the fetch
//            PC, issues one word-aligned request at a time to a
//            variable-latency instruction memory (req/ack), and buffers
//            returned instructions with their PCs in a small queue consumed
//            through a valid/ready interface. A taken branch (Redirect)
//            retargets fetch and flushes all stale work.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock        in   1  rising-edge clock
//   Reset_n      in   1  asynchronous active-low reset
//   MemReq       out  1  request to instruction memory (registered)
//   MemAddr      out 16  request address, stable while MemReq is high
//   MemAck       in   1  memory completes the request this cycle
//   MemData      in  16  returned instruction word
//   Redirect     in   1  taken-branch pulse
//   RedirectAddr in  16  branch target (bit 0 ignored)
//   InstrValid   out  1  queue head valid
//   Instruction  out 16  queue head instruction
//   InstrPC      out 16  PC of queue head
//   InstrReady   in   1  consumer accepts head when InstrValid is high
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd10,
  parameter int          QDEPTH   = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  input  logic        MemAck,
  input  logic [15:0] MemData,
  input  logic        Redirect,
  input  logic [15:0] RedirectAddr,
  output logic        InstrValid,
  output logic [15:0] Instruction,
  output logic [15:0] InstrPC,
  input  logic        InstrReady
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        req_nxt;
  logic [15:0] addr_nxt;
  logic [15:0] fetch_pc, pc_nxt;
  logic        push, pop;

  logic [15:0]      q_instr [QDEPTH];
  logic [15:0]      q_pc    [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      hold_instr, hold_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Queue head presentation. When empty, the outputs keep showing the last
  // head entry rather than whatever stale slot the read pointer lands on.
  // --------------------------------------------------------------------------
  assign InstrValid  = (count != '0);
  assign Instruction = InstrValid ? q_instr[rd_ptr] : hold_instr;
  assign InstrPC     = InstrValid ? q_pc[rd_ptr]    : hold_pc;

  // A redirect flushes the queue; the head handed over in that same cycle is
  // still considered consumed downstream, so no separate pop is needed.
  assign pop = InstrValid && InstrReady && !Redirect;

  // --------------------------------------------------------------------------
  // Fetch FSM: next-state and registered-output values
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_nxt   = MemReq;
    addr_nxt  = MemAddr;
    pc_nxt    = fetch_pc;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        // MemAck here is spurious (or left over from before reset): ignored.
        if (!Redirect && (count < DEPTH_C)) begin
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MemAck) begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
          if (!Redirect) begin
            push   = 1'b1;
            pc_nxt = fetch_pc + 16'd2;
          end
        end else if (Redirect) begin
          // Request already on the bus must still complete; its data is
          // thrown away in DROP.
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (MemAck) begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
    if (Redirect) begin
      pc_nxt = RedirectAddr & 16'hFFFE;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      MemReq   <= 1'b0;
      MemAddr  <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      MemReq   <= req_nxt;
      MemAddr  <= addr_nxt;
      fetch_pc <= pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue control. Issue is gated on count < QDEPTH, and only one
  // request is ever outstanding, so a push can never overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hold_instr <= 16'd0;
      hold_pc    <= 16'd0;
    end else begin
      if (InstrValid) begin
        hold_instr <= q_instr[rd_ptr];
        hold_pc    <= q_pc[rd_ptr];
      end
      if (Redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge Clock) begin
    if (push) begin
      q_instr[wr_ptr] <= MemData;
      q_pc[wr_ptr]    <= MemAddr;
    end
  end

endmodule
`default_nettype wire
